dmem_bank_resp: RTL and testbench

- Responder side of the data-memory access interface driven by the memory-access stage.
- Stores 16-bit words as two 8-bit byte banks (low/high) behind a single bank port.
- Accepts reads and posted writes: writes enter a small store queue and drain to the banks on idle cycles.
- Reads are registered (1-cycle latency), with forwarding from the store queue so read-after-write is always coherent.

---
 rtl/dmem_bank_resp.sv | 124 ++++++++++++
 tb/tb_dmem_bank_resp.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dmem_bank_resp.sv
// dmem_bank_resp: data-memory responder with two byte banks, a posted-write
// store queue that drains on idle cycles, and registered reads that forward
// from the queue so read-after-write always returns the newest data.
module dmem_bank_resp #(
  parameter int ADDR_W   = 8,  // word-address bits used (must be < 16)
  parameter int WQ_DEPTH = 2   // store-queue entries (>= 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_mem_addr,
  input  logic        mem_modif,
  input  logic        wr_rd_enable,
  input  logic [7:0]  d_mem_wr_data_l,
  input  logic [7:0]  d_mem_wr_data_h,
  output logic [7:0]  d_mem_rd_data_l,
  output logic [7:0]  d_mem_rd_data_h,
  output logic        rd_valid,
  output logic        d_mem_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = $clog2(WQ_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WQ_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [7:0]        hi;
    logic [7:0]        lo;
  } entry_t;

  // Byte banks; entry 0 of the queue is always the oldest.
  logic [7:0] bank_l [DEPTH];
  logic [7:0] bank_h [DEPTH];
  entry_t     q      [WQ_DEPTH];
  entry_t     q_n    [WQ_DEPTH];
  logic [CW-1:0] cnt, cnt_n;

  logic [ADDR_W-1:0] idx;
  logic              is_rd, is_wr, drain;
  entry_t            new_entry;
  logic [15:0]       fwd_word;
  logic              unused_addr_hi;

  assign idx            = d_mem_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^d_mem_addr[15:ADDR_W];
  assign is_rd          = mem_modif & ~wr_rd_enable;
  assign is_wr          = mem_modif &  wr_rd_enable;
  assign new_entry      = '{idx: idx, hi: d_mem_wr_data_h, lo: d_mem_wr_data_l};

  // Next queue state: enqueue on writes, pop the head on idle or forced drain.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    q_n   = q;
    cnt_n = cnt;
    drain = 1'b0;
    if (is_wr) begin
      if (cnt == FULL) begin
        // Full queue: retire the head to the banks on this edge, shift, and
        // append the new write at the tail so it is never dropped.
        drain = 1'b1;
        for (int i = 0; i < WQ_DEPTH - 1; i++) q_n[i] = q[i+1];
        q_n[WQ_DEPTH-1] = new_entry;
      end else begin
        for (int i = 0; i < WQ_DEPTH; i++)
          if (CW'(i) == cnt) q_n[i] = new_entry;
        cnt_n = cnt + 1'b1;
      end
    end else if (!mem_modif && cnt != '0) begin
      drain = 1'b1;
      for (int i = 0; i < WQ_DEPTH - 1; i++) q_n[i] = q[i+1];
      cnt_n = cnt - 1'b1;
    end
  end

  // Read source: youngest valid matching queue entry, else the banks.
  always_comb begin
    fwd_word = {bank_h[idx], bank_l[idx]};
    // Ascending scan lets a later (younger) match override an older one.
    for (int i = 0; i < WQ_DEPTH; i++)
      if (CW'(i) < cnt && q[i].idx == idx) fwd_word = {q[i].hi, q[i].lo};
  end

  // Queue occupancy and the full flag, registered together.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      cnt        <= '0;
      d_mem_busy <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      d_mem_busy <= (cnt_n == FULL);
    end
  end

  // Queue payload; only entries below cnt are ever consulted.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; validity is tracked by cnt alone.
    for (int i = 0; i < WQ_DEPTH; i++) q[i] <= q_n[i];
  end

  // Bank write port: retire the queue head; a reset edge suppresses the drain.
  always_ff @(posedge clk) begin
    if (drain && !reset) begin
      bank_l[q[0].idx] <= q[0].lo;
      bank_h[q[0].idx] <= q[0].hi;
    end
  end

  // Registered read data, held outside READ cycles; rd_valid pulses per read.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_mem_rd_data_l <= 8'h00;
      d_mem_rd_data_h <= 8'h00;
      rd_valid        <= 1'b0;
    end else begin
      rd_valid <= is_rd;
      if (is_rd) begin
        d_mem_rd_data_l <= fwd_word[7:0];
        d_mem_rd_data_h <= fwd_word[15:8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_bank_resp.sv
// tb_dmem_bank_resp: table-driven directed test of dmem_bank_resp, plus a
// hand-written duplicate-index forced-drain sequence.
module tb_dmem_bank_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] d_mem_addr;
  logic        mem_modif;
  logic        wr_rd_enable;
  logic [7:0]  d_mem_wr_data_l;
  logic [7:0]  d_mem_wr_data_h;
  logic [7:0]  d_mem_rd_data_l;
  logic [7:0]  d_mem_rd_data_h;
  logic        rd_valid;
  logic        d_mem_busy;

  int checks = 0;
  int errors = 0;

  dmem_bank_resp #(.ADDR_W(8), .WQ_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .d_mem_addr      (d_mem_addr),
    .mem_modif       (mem_modif),
    .wr_rd_enable    (wr_rd_enable),
    .d_mem_wr_data_l (d_mem_wr_data_l),
    .d_mem_wr_data_h (d_mem_wr_data_h),
    .d_mem_rd_data_l (d_mem_rd_data_l),
    .d_mem_rd_data_h (d_mem_rd_data_h),
    .rd_valid        (rd_valid),
    .d_mem_busy      (d_mem_busy)
  );

  always #5 clk = ~clk;

  // One stimulus cycle and the outputs expected just after its rising edge.
  typedef struct {
    logic        rst;
    logic        mm;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_valid;
    logic        exp_busy;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic add(input logic rst, input logic mm, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_data,
                     input logic exp_valid, input logic exp_busy);
    vec_t v;
    v = '{rst, mm, wr, addr, wdata, exp_data, exp_valid, exp_busy};
    vq.push_back(v);
  endtask

  // Drive one cycle at the falling edge, then let the rising edge happen.
  task automatic step(input logic rst, input logic mm, input logic wr,
                      input logic [15:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    reset           = rst;
    mem_modif       = mm;
    wr_rd_enable    = wr;
    d_mem_addr      = addr;
    d_mem_wr_data_h = wdata[15:8];
    d_mem_wr_data_l = wdata[7:0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] exp_data,
                            input logic exp_valid, input logic exp_busy);
    check({tag, " rd_data"}, {d_mem_rd_data_h, d_mem_rd_data_l}, exp_data);
    check({tag, " rd_valid"}, {15'd0, rd_valid}, {15'd0, exp_valid});
    check({tag, " busy"}, {15'd0, d_mem_busy}, {15'd0, exp_busy});
  endtask

  initial begin
    reset = 1'b1; mem_modif = 1'b0; wr_rd_enable = 1'b0;
    d_mem_addr = 16'h0; d_mem_wr_data_l = 8'h0; d_mem_wr_data_h = 8'h0;

    //  rst   mm    wr    addr      wdata     exp_data  vld   busy
    // Reset, then preload bank[5]=BEEF and bank[9]=0000 through the port.
    add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'h0009, 16'h0000, 16'h0000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    // Bank read of idx 5, rd_valid exactly one cycle.
    add(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    // Write idx 3, forwarded read, drain, bank read.
    add(1'b0, 1'b1, 1'b1, 16'h0003, 16'h1234, 16'hBEEF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b1, 1'b0);
    // Duplicate idx 7: youngest wins for forwarding and after drain.
    add(1'b0, 1'b1, 1'b1, 16'h0007, 16'h1111, 16'h1234, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'h0007, 16'h2222, 16'h1234, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 16'h2222, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2222, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 16'h2222, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2222, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 16'h2222, 1'b1, 1'b0);
    // Three writes: third forces idx 1 into the bank; busy held until idle.
    add(1'b0, 1'b1, 1'b1, 16'h0001, 16'hA1A1, 16'h2222, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'h0002, 16'hB2B2, 16'h2222, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 16'h0003, 16'hC3C3, 16'h2222, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'hA1A1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'hB2B2, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'hC3C3, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC3C3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC3C3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'hB2B2, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'hC3C3, 1'b1, 1'b0);
    // Pending write to idx 9 lost to reset (reset during an idle cycle).
    add(1'b0, 1'b1, 1'b1, 16'h0009, 16'h5555, 16'hC3C3, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0009, 16'h0000, 16'h0000, 1'b1, 1'b0);
    // Upper address bits ignored.
    add(1'b0, 1'b1, 1'b0, 16'hFF09, 16'h0000, 16'h0000, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 16'h0109, 16'h6789, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0009, 16'h0000, 16'h6789, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h6789, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'hAB09, 16'h0000, 16'h6789, 1'b1, 1'b0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].mm, vq[i].wr, vq[i].addr, vq[i].wdata);
      check_outs($sformatf("vec%0d", i), vq[i].exp_data, vq[i].exp_valid, vq[i].exp_busy);
    end

    // Three writes to one idx: the forced drain retires the oldest, reads
    // must still see the youngest, both from the queue and after draining.
    step(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0101);
    check_outs("dup w1", 16'h6789, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0202);
    check_outs("dup w2", 16'h6789, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0303);
    check_outs("dup w3", 16'h6789, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    check_outs("dup rd q", 16'h0303, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_outs("dup idle1", 16'h0303, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check_outs("dup idle2", 16'h0303, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    check_outs("dup rd other", 16'hBEEF, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    check_outs("dup rd bank", 16'h0303, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
